// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with input synchroniser,
// false-start rejection, parity/framing error flags and break detection.
//
// Parameters
//   DBIT        data bits per frame (5..9), LSB first
//   OVERSAMPLE  s_tick pulses per bit period (even, 8..32)
//   PARITY      0 = none, 1 = odd, 2 = even
//   SB          stop bits (1 or 2)
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous reset, active-high
//   rx            asynchronous serial line, idle high
//   s_tick        oversample enable, one clk wide
//   rx_dout       last completed word, held until next rx_done_tick
//   rx_done_tick  one-clk pulse when a frame completes
//   parity_err    parity mismatch for the last frame
//   frame_err     a stop-bit sample of the last frame was 0
//   break_det     data, parity and first stop bit all sampled 0
//   busy          receiver is inside a frame (not IDLE)
module uart_rx_cfg #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned SB         = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            busy
);

    localparam int unsigned S_W = $clog2(OVERSAMPLE);
    localparam int unsigned N_W = $clog2(DBIT + 1);

    localparam logic [S_W-1:0] S_MID       = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_END       = S_W'(OVERSAMPLE - 1);
    localparam logic [N_W-1:0] N_DATA_LAST = N_W'(DBIT - 1);
    localparam logic [N_W-1:0] N_STOP_LAST = N_W'(SB - 1);
    localparam logic           PAR_ODD     = (PARITY == 1);
    localparam logic           HAS_PARITY  = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t state, state_next;

    logic            rx_meta, rx_s;
    logic            armed, armed_next;
    logic [S_W-1:0]  s_cnt, s_next;
    logic [N_W-1:0]  n_cnt, n_next;
    logic [DBIT-1:0] shreg, shreg_next;
    logic            par_s, par_s_next;
    logic            perr_r, perr_next;
    logic            ferr_r, ferr_next;
    logic            brk_r, brk_next;
    logic            ferr_now, brk_now;

    logic [DBIT-1:0] dout_next;
    logic            done_next, perr_out_next, ferr_out_next, brk_out_next, busy_next;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= ST_IDLE;
            armed        <= 1'b0;
            s_cnt        <= '0;
            n_cnt        <= '0;
            shreg        <= '0;
            par_s        <= 1'b0;
            perr_r       <= 1'b0;
            ferr_r       <= 1'b0;
            brk_r        <= 1'b0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_s         <= rx_meta;
            state        <= state_next;
            armed        <= armed_next;
            s_cnt        <= s_next;
            n_cnt        <= n_next;
            shreg        <= shreg_next;
            par_s        <= par_s_next;
            perr_r       <= perr_next;
            ferr_r       <= ferr_next;
            brk_r        <= brk_next;
            rx_dout      <= dout_next;
            rx_done_tick <= done_next;
            parity_err   <= perr_out_next;
            frame_err    <= ferr_out_next;
            break_det    <= brk_out_next;
            busy         <= busy_next;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_next    = state;
        armed_next    = armed;
        s_next        = s_cnt;
        n_next        = n_cnt;
        shreg_next    = shreg;
        par_s_next    = par_s;
        perr_next     = perr_r;
        ferr_next     = ferr_r;
        brk_next      = brk_r;
        ferr_now      = ferr_r;
        brk_now       = brk_r;
        dout_next     = rx_dout;
        done_next     = 1'b0;
        perr_out_next = parity_err;
        ferr_out_next = frame_err;
        brk_out_next  = break_det;

        case (state)
            ST_IDLE: begin
                // A line that has not been seen high (after reset or a
                // framing error) must not be taken as a start bit.
                armed_next = armed | rx_s;
                if (armed && !rx_s) begin
                    s_next     = '0;
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (s_cnt == S_MID) begin
                        if (rx_s) begin
                            state_next = ST_IDLE;
                        end else begin
                            s_next     = '0;
                            n_next     = '0;
                            perr_next  = 1'b0;
                            ferr_next  = 1'b0;
                            brk_next   = 1'b0;
                            state_next = ST_DATA;
                        end
                    end else begin
                        s_next = s_cnt + S_W'(1);
                    end
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (s_cnt == S_END) begin
                        s_next     = '0;
                        shreg_next = {rx_s, shreg[DBIT-1:1]};
                        if (n_cnt == N_DATA_LAST) begin
                            n_next     = '0;
                            state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            n_next = n_cnt + N_W'(1);
                        end
                    end else begin
                        s_next = s_cnt + S_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (s_tick) begin
                    if (s_cnt == S_END) begin
                        s_next     = '0;
                        n_next     = '0;
                        par_s_next = rx_s;
                        perr_next  = (((^shreg) ^ rx_s) != PAR_ODD);
                        state_next = ST_STOP;
                    end else begin
                        s_next = s_cnt + S_W'(1);
                    end
                end
            end

            ST_STOP: begin
                if (s_tick) begin
                    if (s_cnt == S_END) begin
                        s_next   = '0;
                        ferr_now = ferr_r | ~rx_s;
                        // Break is judged on the first stop bit only
                        if (n_cnt == '0) begin
                            brk_now = (shreg == '0) && (!HAS_PARITY || !par_s) && !rx_s;
                        end
                        ferr_next = ferr_now;
                        brk_next  = brk_now;
                        if (n_cnt == N_STOP_LAST) begin
                            n_next        = '0;
                            state_next    = ST_IDLE;
                            done_next     = 1'b1;
                            dout_next     = shreg;
                            perr_out_next = perr_r;
                            ferr_out_next = ferr_now;
                            brk_out_next  = brk_now;
                            if (ferr_now) begin
                                armed_next = 1'b0;
                            end
                        end else begin
                            n_next = n_cnt + N_W'(1);
                        end
                    end else begin
                        s_next = s_cnt + S_W'(1);
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

endmodule
